// File: rtl/block_lane_engine.sv
// Block Killer game core: scrolling block columns, cursor, shot handling and BCD score.
// Optional build macro SPEEDUP_EN shortens the scroll period as the score grows.
module block_lane_engine #(
  parameter int          NUM_COLS     = 4,
  parameter int          DEPTH        = 24,
  parameter int          TICK_DIV     = 2_500_000,
  parameter int          SCORE_DIGITS = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          CLK_50M,
  input  logic                          RST,
  input  logic [1:0]                    game_state,
  input  logic                          left_key_press,
  input  logic                          right_key_press,
  input  logic                          down_key_press,
  output logic [NUM_COLS*DEPTH-1:0]     columns,
  output logic [$clog2(NUM_COLS)-1:0]   player_col,
  output logic                          hit,
  output logic                          game_over,
  output logic [4*SCORE_DIGITS-1:0]     score_bcd
);
  // game_state | meaning
  // IDLE       | clear playfield and score, LFSR free-runs
  // PLAY       | scroll, move and shoot (unless frozen after game over)
  // OVER       | hold everything
  // PAUSE      | hold everything, tick counter included
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam int CW    = $clog2(NUM_COLS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SW    = 4*SCORE_DIGITS;

  logic [NUM_COLS*DEPTH-1:0] cols_q, cols_d;
  logic [CW-1:0]             pcol_q, pcol_d;
  logic [SW-1:0]             score_q, score_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, reload;
  logic [15:0]               lfsr_q, lfsr_d, lfsr_next;
  logic                      frozen_q, frozen_d;
  logic                      hit_q, hit_d, go_q, go_d;
  logic [DEPTH-1:0]          cur_col, col_v;
  logic                      shot_hit, tick, any_bottom;
  logic [CW-1:0]             spawn_col;

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry, all9;
    r     = s;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (s[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (s[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = s[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return all9 ? s : r;
  endfunction

`ifdef SPEEDUP_EN
  // Period shrinks by TICK_DIV/8 per ten points, never below TICK_DIV/4.
  function automatic logic [CNT_W-1:0] speed_reload(input logic [SW-1:0] s);
    int unsigned lvl, wt, per;
    lvl = 0;
    wt  = 1;
    for (int i = 1; i < SCORE_DIGITS; i++) begin
      lvl = lvl + wt * 32'(s[4*i +: 4]);
      wt  = wt * 10;
    end
    if (32'(TICK_DIV/8) * lvl > 32'(TICK_DIV - TICK_DIV/4)) per = 32'(TICK_DIV/4);
    else                                                   per = 32'(TICK_DIV) - 32'(TICK_DIV/8) * lvl;
    return CNT_W'(per - 1);
  endfunction

  assign reload = speed_reload(score_q);
`else
  assign reload = CNT_W'(TICK_DIV - 1);
`endif

  assign cur_col   = cols_q[32'(pcol_q)*DEPTH +: DEPTH];
  assign shot_hit  = down_key_press && (cur_col != '0);
  assign tick      = (cnt_q == '0);
  assign spawn_col = CW'(32'(lfsr_q[3:0]) % NUM_COLS);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    cols_d     = cols_q;
    pcol_d     = pcol_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    frozen_d   = frozen_q;
    hit_d      = 1'b0;
    go_d       = 1'b0;
    col_v      = '0;
    any_bottom = 1'b0;
    if (game_state == ST_IDLE) begin
      cols_d   = '0;
      pcol_d   = '0;
      score_d  = '0;
      cnt_d    = CNT_W'(TICK_DIV - 1);
      lfsr_d   = lfsr_next;
      frozen_d = 1'b0;
    end else if (game_state == ST_PLAY && !frozen_q) begin
      // Shot acts on pre-shift contents; bottom check sees the shot result.
      for (int k = 0; k < NUM_COLS; k++) begin
        col_v = cols_q[k*DEPTH +: DEPTH];
        if (shot_hit && pcol_q == CW'(k)) col_v = col_v & (col_v - DEPTH'(1));
        if (tick) begin
          any_bottom = any_bottom | col_v[0];
          col_v      = {1'b0, col_v[DEPTH-1:1]};
          if (lfsr_q[15] && spawn_col == CW'(k)) col_v[DEPTH-1] = 1'b1;
        end
        cols_d[k*DEPTH +: DEPTH] = col_v;
      end
      if (left_key_press && !right_key_press && pcol_q != '0)
        pcol_d = pcol_q - CW'(1);
      if (right_key_press && !left_key_press && pcol_q != CW'(NUM_COLS - 1))
        pcol_d = pcol_q + CW'(1);
      hit_d = shot_hit;
      if (shot_hit) score_d = bcd_inc(score_q);
      if (tick) begin
        cnt_d    = reload;
        lfsr_d   = lfsr_next;
        go_d     = any_bottom;
        frozen_d = any_bottom;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      cols_q   <= '0;
      pcol_q   <= '0;
      score_q  <= '0;
      cnt_q    <= CNT_W'(TICK_DIV - 1);
      lfsr_q   <= LFSR_SEED;
      frozen_q <= 1'b0;
      hit_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      cols_q   <= cols_d;
      pcol_q   <= pcol_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      frozen_q <= frozen_d;
      hit_q    <= hit_d;
      go_q     <= go_d;
    end
  end

  assign columns    = cols_q;
  assign player_col = pcol_q;
  assign score_bcd  = score_q;
  assign hit        = hit_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_block_lane_engine.sv
// Self-checking bench for block_lane_engine: directed openings, then randomized play
// compared every cycle against a behavioural game model.
module tb_block_lane_engine;
  localparam int NC = 4;
  localparam int D  = 8;
  localparam int TD = 8;
  localparam int SD = 2;
  localparam int SMAX = 99;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2, PAUSE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [1:0]    gs = PLAY;
  logic          lk = 1'b0, rk = 1'b0, dk = 1'b0;
  logic [NC*D-1:0] columns;
  logic [1:0]    pcol;
  logic          hit, go;
  logic [4*SD-1:0] score;

  block_lane_engine #(
    .NUM_COLS(NC), .DEPTH(D), .TICK_DIV(TD), .SCORE_DIGITS(SD), .LFSR_SEED(SEED)
  ) dut (
    .CLK_50M(clk), .RST(rst), .game_state(gs),
    .left_key_press(lk), .right_key_press(rk), .down_key_press(dk),
    .columns(columns), .player_col(pcol), .hit(hit), .game_over(go), .score_bcd(score)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model: playfield as per-column bit vectors, cycles since last tick, integer score
  bit [D-1:0] m_cols[NC];
  int         m_pcol, m_score, m_phase, m_per;
  bit [15:0]  m_lfsr;
  bit         m_frozen, m_hit, m_go;

  function automatic bit [15:0] lfsr_adv(input bit [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  function automatic int period_for(input int s);
    int p;
    p = TD;
`ifdef SPEEDUP_EN
    p = TD - (TD/8) * (s / 10);
    if (p < TD/4) p = TD/4;
`endif
    return p;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NC; k++) m_cols[k] = '0;
    m_pcol = 0; m_score = 0; m_phase = 0; m_per = TD;
    m_frozen = 0; m_hit = 0; m_go = 0;
  endfunction

  function automatic void model_step();
    bit tck;
    int old_score, sc;
    if (rst) begin
      model_clear();
      m_lfsr = SEED;
      return;
    end
    m_hit = 0;
    m_go  = 0;
    if (gs == IDLE) begin
      model_clear();
      m_lfsr = lfsr_adv(m_lfsr);
    end else if (gs == PLAY && !m_frozen) begin
      tck = (m_phase == m_per - 1);
      old_score = m_score;
      if (dk && m_cols[m_pcol] != 0) begin
        for (int b = 0; b < D; b++)
          if (m_cols[m_pcol][b]) begin
            m_cols[m_pcol][b] = 1'b0;
            break;
          end
        m_hit = 1;
        if (m_score < SMAX) m_score++;
      end
      if (lk && !rk && m_pcol > 0) m_pcol--;
      if (rk && !lk && m_pcol < NC - 1) m_pcol++;
      if (tck) begin
        for (int k = 0; k < NC; k++) if (m_cols[k][0]) m_go = 1;
        if (m_go) m_frozen = 1;
        for (int k = 0; k < NC; k++) m_cols[k] = m_cols[k] >> 1;
        if (m_lfsr[15]) begin
          sc = int'(m_lfsr[3:0]) % NC;
          m_cols[sc][D-1] = 1'b1;
        end
        m_lfsr  = lfsr_adv(m_lfsr);
        m_per   = period_for(old_score);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endfunction

  function automatic logic [NC*D-1:0] m_pack();
    logic [NC*D-1:0] v;
    for (int k = 0; k < NC; k++) v[k*D +: D] = m_cols[k];
    return v;
  endfunction

  function automatic bit m_any_block();
    for (int k = 0; k < NC; k++) if (m_cols[k] != 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("columns",    32'(columns), 32'(m_pack()));
    chk("player_col", 32'(pcol),    32'(m_pcol));
    chk("hit",        32'(hit),     32'(m_hit));
    chk("game_over",  32'(go),      32'(m_go));
    chk("score_bcd",  32'(score),   {24'd0, 4'(m_score / 10), 4'(m_score % 10)});
  endtask

  task automatic cycle(input logic r, input logic [1:0] s, input logic l, input logic ri, input logic d);
    rst = r; gs = s; lk = l; rk = ri; dk = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Chases the lowest block; sometimes holds a bottom-row shot so it lands on the tick.
  task automatic smart_keys(output logic l, output logic r, output logic d);
    int tgt, best;
    tgt = -1; best = D;
    for (int k = 0; k < NC; k++)
      for (int b = 0; b < D; b++)
        if (m_cols[k][b] && b < best) begin
          best = b;
          tgt  = k;
        end
    l = 0; r = 0; d = 0;
    if (tgt >= 0) begin
      if (m_pcol < tgt)      r = 1;
      else if (m_pcol > tgt) l = 1;
      else if (!(best == 0 && m_phase >= m_per - 3 && m_phase < m_per - 1)) d = 1;
    end
    if ($urandom_range(0, 19) == 0) begin
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic l, r, d;
    logic [NC*D-1:0] snap;
    logic [2:0] changed;
    bit found;
    int rr;

    m_lfsr = SEED;
    model_clear();

    cycle(1, PLAY, 0, 0, 0);
    cycle(1, PLAY, 1, 0, 1);
    chk("reset_columns", 32'(columns), 32'h0);
    chk("reset_score",   32'(score),   32'h0);
    chk("reset_pcol",    32'(pcol),    32'h0);

    // First ticks from the seed: spawn col1, shift, spawn col3.
    for (int i = 0; i < 8; i++) cycle(0, PLAY, 0, 0, 0);
    chk("tick1_spawn", 32'(columns), 32'h0000_8000);
    for (int i = 0; i < 8; i++) cycle(0, PLAY, 0, 0, 0);
    chk("tick2_shift", 32'(columns), 32'h0000_4000);
    for (int i = 0; i < 8; i++) cycle(0, PLAY, 0, 0, 0);
    chk("tick3_spawn", 32'(columns), 32'h8000_2000);

    cycle(0, PLAY, 0, 1, 0);
    chk("move_right", 32'(pcol), 32'd1);
    cycle(0, PLAY, 0, 0, 1);
    chk("shot_hit",     32'(hit),     32'd1);
    chk("shot_columns", 32'(columns), 32'h8000_0000);
    chk("shot_score",   32'(score),   32'h01);
    cycle(0, PLAY, 0, 0, 0);
    chk("hit_one_cycle", 32'(hit), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, PLAY, 0, 1, 0);
      cycle(0, PLAY, 0, 0, 0);
    end
    chk("right_saturate", 32'(pcol), 32'd3);
    cycle(0, PLAY, 1, 1, 0);
    chk("left_right_hold", 32'(pcol), 32'd3);
    cycle(0, PLAY, 1, 0, 0);
    cycle(0, PLAY, 0, 0, 1);
    chk("empty_shot_hit",   32'(hit),   32'd0);
    chk("empty_shot_score", 32'(score), 32'h01);

    // Long skilled game with occasional pause/over: drives score into saturation.
    for (int i = 0; i < 3000; i++) begin
      rr = $urandom_range(0, 99);
      smart_keys(l, r, d);
      if (rr < 92)      cycle(0, PLAY, l, r, d);
      else if (rr < 97) cycle(0, PAUSE, l, r, d);
      else              cycle(0, OVER, l, r, d);
    end
    chk("score_saturated", 32'(score), 32'h99);

    // Pause mid-period: the tick must land on the third PLAY cycle after resume.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_phase == 5 && m_any_block() && !m_frozen) found = 1;
      else cycle(0, PLAY, 0, 0, 0);
    end
    chk("pause_setup", 32'(found), 32'd1);
    snap = m_pack();
    for (int i = 0; i < 100; i++) cycle(0, PAUSE, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
    changed = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, PLAY, 0, 0, 0);
      changed[i] = (columns !== snap);
    end
    chk("pause_resume_tick", 32'(changed), 32'b100);

    // No shooting until a block falls out, then everything must freeze.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(0, PLAY, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 0);
      if (go === 1'b1) found = 1;
    end
    chk("game_over_seen", 32'(found), 32'd1);
    for (int i = 0; i < 60; i++) cycle(0, PLAY, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
    cycle(0, IDLE, 0, 0, 0);
    cycle(0, IDLE, 1, 0, 1);
    chk("idle_columns", 32'(columns), 32'h0);
    chk("idle_score",   32'(score),   32'h0);
    chk("idle_pcol",    32'(pcol),    32'h0);

    // Randomized games, alternating chasing and random keys.
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) cycle(0, IDLE, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
        rr = $urandom_range(0, 99);
        if (g % 2 == 0) smart_keys(l, r, d);
        else begin
          l = ($urandom_range(0, 3) == 0);
          r = ($urandom_range(0, 3) == 0);
          d = ($urandom_range(0, 2) == 0);
        end
        if ($urandom_range(0, 299) == 0) cycle(1, PLAY, l, r, d);
        else if (rr < 85) cycle(0, PLAY, l, r, d);
        else if (rr < 92) cycle(0, PAUSE, l, r, d);
        else if (rr < 97) cycle(0, OVER, l, r, d);
        else              cycle(0, IDLE, l, r, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
